sevenseg_scan_ctrl: RTL and testbench

//  Time-multiplexes NDIG digits onto one shared 3-bit seven-segment decoder (segin/en -> segout).

---
 rtl/sevenseg_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Scans NDIG 3-bit digits onto one shared segment decoder: DWELL cycles drive, BLANK_CYC blanking per digit.
// Latency: all outputs registered; digit select trails seg_en by one cycle. load_ready drops for a held frame.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading-zero digits (slot timing unchanged).
module sevenseg_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int DWELL     = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [3*NDIG-1:0] load_data,
    output logic [2:0]        seg_code,
    output logic              seg_en,
    output logic [NDIG-1:0]   dig_sel,
    output logic              frame_done
);

    localparam int CMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(NDIG);
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic [3*NDIG-1:0] disp;
    logic [3*NDIG-1:0] shadow;
    logic              pending;
    logic [3*NDIG-1:0] next0;

    function automatic logic [2:0] dig_of(input logic [3*NDIG-1:0] f, input logic [IW-1:0] i);
        return f[3*int'(i) +: 3];
    endfunction

    // A slot is suppressed when it and every higher digit are zero; digit 0 always shows.
    function automatic logic blank_slot(input logic [3*NDIG-1:0] f, input logic [IW-1:0] i);
        logic z;
        z = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
            if (k >= int'(i) && f[3*k +: 3] != 3'd0) z = 1'b0;
        end
        return LZB && (i != '0) && z;
    endfunction

    // Frame that digit 0 will show: a pending load takes effect on this boundary.
    assign next0 = pending ? shadow : disp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            disp       <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            load_ready <= 1'b1;
            seg_code   <= 3'd0;
            seg_en     <= 1'b0;
            dig_sel    <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load_valid && load_ready) begin
                shadow     <= load_data;
                pending    <= 1'b1;
                load_ready <= 1'b0;
            end
            if (state == IDLE) begin
                seg_en  <= 1'b0;
                dig_sel <= '1;
                idx     <= '0;
                cnt     <= '0;
                if (pending) begin
                    disp       <= shadow;
                    pending    <= 1'b0;
                    load_ready <= 1'b1;
                end
                if (enable) begin
                    state    <= DRIVE;
                    seg_code <= dig_of(next0, '0);
                    seg_en   <= 1'b1;
                end
            end else if (!enable) begin
                state   <= IDLE;
                seg_en  <= 1'b0;
                dig_sel <= '1;
                idx     <= '0;
                cnt     <= '0;
            end else if (state == DRIVE) begin
                if (cnt == CW'(DWELL - 1)) begin
                    state   <= BLANK;
                    cnt     <= '0;
                    seg_en  <= 1'b0;
                    dig_sel <= '1;
                end else begin
                    cnt <= cnt + CW'(1);
                    if (cnt == '0 && !blank_slot(disp, idx))
                        dig_sel <= ~(NDIG'(1) << idx);
                end
            end else begin
                if (cnt == CW'(BLANK_CYC - 1)) begin
                    state <= DRIVE;
                    cnt   <= '0;
                    if (idx == IW'(NDIG - 1)) begin
                        frame_done <= 1'b1;
                        idx        <= '0;
                        seg_code   <= dig_of(next0, '0);
                        seg_en     <= 1'b1;
                        if (pending) begin
                            disp       <= shadow;
                            pending    <= 1'b0;
                            load_ready <= 1'b1;
                        end
                    end else begin
                        idx      <= idx + IW'(1);
                        seg_code <= dig_of(disp, idx + IW'(1));
                        seg_en   <= !blank_slot(disp, idx + IW'(1));
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: directed scenarios then random enable/load traffic, checked each cycle
// against a position-in-frame reference model.
module tb_sevenseg_scan_ctrl;

    localparam int NDIG = 4, DWELL = 4, BLANK_CYC = 2;
    localparam int P  = DWELL + BLANK_CYC;
    localparam int FP = NDIG * P;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [3*NDIG-1:0] load_data = '0;
    logic [2:0]        seg_code;
    logic              seg_en;
    logic [NDIG-1:0]   dig_sel;
    logic              frame_done;

    sevenseg_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .seg_code(seg_code),
        .seg_en(seg_en), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: running flag, cycle count since scan start, displayed/held frames.
    bit                m_run, m_pend, m_ready;
    int                m_k;
    logic [3*NDIG-1:0] m_disp, m_shadow;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_ready = 1; m_k = 0; m_disp = '0; m_shadow = '0;
    endtask

    task automatic check_outputs();
        int f, d, o;
        bit blank;
        logic [NDIG-1:0] e_sel;
        chk("load_ready", load_ready, m_ready);
        if (!m_run) begin
            chk("idle_seg_en", seg_en, 0);
            chk("idle_dig_sel", dig_sel, {NDIG{1'b1}});
            chk("idle_frame_done", frame_done, 0);
        end else begin
            f = m_k % FP; d = f / P; o = f % P;
            blank = 0;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (d > 0) && ((m_disp >> (3 * d)) == 0);
`endif
            e_sel = {NDIG{1'b1}};
            if (o >= 1 && o < DWELL && !blank) e_sel[d] = 1'b0;
            chk("seg_en", seg_en, (o < DWELL) && !blank);
            chk("dig_sel", dig_sel, e_sel);
            chk("frame_done", frame_done, (m_k > 0) && (f == 0));
            if (o < DWELL && !blank) chk("seg_code", seg_code, 32'((m_disp >> (3 * d)) & 7));
        end
    endtask

    task automatic step(input int n);
        bit xfer;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                xfer = load_valid && m_ready;
                if (!m_run) begin
                    if (m_pend) begin m_disp = m_shadow; m_pend = 0; m_ready = 1; end
                    if (enable) begin m_run = 1; m_k = 0; end
                end else if (!enable) begin
                    m_run = 0;
                end else begin
                    m_k++;
                    if (m_k % FP == 0 && m_pend) begin m_disp = m_shadow; m_pend = 0; m_ready = 1; end
                end
                if (xfer) begin m_shadow = load_data; m_pend = 1; m_ready = 0; end
            end
            #1;
            check_outputs();
        end
    endtask

    task automatic load_once(input logic [3*NDIG-1:0] v);
        load_valid = 1'b1; load_data = v;
        step(1);
        load_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        // Async reset seen before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_dig_sel", dig_sel, 4'b1111);
        chk("rst_seg_en", seg_en, 0);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_frame_done", frame_done, 0);
        #1 rst_n = 1'b1;

        // Load while idle, then scan several frames.
        load_once(12'o7531);
        step(3);
        enable = 1'b1;
        step(3 * FP + 2);

        // Load mid-frame: held until the wrap, no tearing.
        for (int n = 0; n < FP && (m_k % FP) != 2 * P; n++) step(1);
        load_once(12'o2222);
        step(FP + 8);

        // Enable drops in the second drive cycle of digit 1, then re-enable.
        for (int n = 0; n < FP && (m_k % FP) != P + 1; n++) step(1);
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        step(FP + 4);

        // Async reset mid-drive with a load pending.
        for (int n = 0; n < FP && (m_k % FP) != 1; n++) step(1);
        load_once(12'o4444);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        step(2);
        #2 rst_n = 1'b1;
        step(FP + 2);

        // Leading-zero frame.
        enable = 1'b0;
        load_once(12'o0030);
        step(2);
        enable = 1'b1;
        step(FP + 2);

        // Random enable/load traffic.
        for (int c = 0; c < 1500; c++) begin
            if (enable) enable = ($urandom_range(0, 59) != 0);
            else        enable = ($urandom_range(0, 3) == 0);
            load_valid = ($urandom_range(0, 5) == 0);
            load_data  = 12'($urandom() >> $urandom_range(20, 32));
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
